// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the configurable UART transmitter.
//   - baud divisors for a 50 MHz clock and the baud_sel -> divisor lookup
//   - parity_mode encoding
//   - transmitter FSM state enum
package uart_pkg;

   // Each bit lasts DIV+1 clocks.
   localparam int unsigned Div9600   = 5208;
   localparam int unsigned Div19200  = 2603;
   localparam int unsigned Div38400  = 1301;
   localparam int unsigned Div57600  = 867;
   localparam int unsigned Div115200 = 434;
   localparam int unsigned Div256000 = 195;

   typedef enum logic [1:0] {
      ParNone = 2'b00,
      ParEven = 2'b01,
      ParOdd  = 2'b10,
      ParRsvd = 2'b11
   } parity_e;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   // Unused selector codes fall back to the slowest rate.
   function automatic int unsigned baud_div(input logic [2:0] sel);
      int unsigned div;
      case (sel)
         3'd0:    div = Div9600;
         3'd1:    div = Div19200;
         3'd2:    div = Div38400;
         3'd3:    div = Div57600;
         3'd4:    div = Div115200;
         3'd5:    div = Div256000;
         default: div = Div9600;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding transmit payloads.
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry, valid while !empty
//   full, empty, count : occupancy status
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_BITS   = 9,
   localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [MAX_BITS-1:0] wdata,
   output logic [MAX_BITS-1:0] rdata,
   output logic                full,
   output logic                empty,
   output logic [AW:0]         count
);

   localparam logic [AW:0] DepthCnt = (AW + 1)'(FIFO_DEPTH);

   logic [MAX_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         count_q;
   logic                do_push, do_pop;

   assign full    = (count_q == DepthCnt);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with input FIFO.
//   clk, rst     : 50 MHz clock, synchronous active-high reset
//   baud_sel     : rate select (divisor table in uart_pkg)
//   data_len     : data bits per frame, clamped to 5..MAX_BITS
//   parity_mode  : none / even / odd (reserved = none)
//   stop2        : two stop bits when set
//   tx_data, tx_valid, tx_ready : payload push handshake (tx_ready = not full)
//   busy         : frame on the line or payload queued
//   fifo_count   : FIFO occupancy
//   rs_tx        : serial output, idle high
// Configuration is sampled when a payload is popped, so changes apply per frame.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned MAX_BITS   = 9,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_W      = 13,
   localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          baud_sel,
   input  logic [3:0]          data_len,
   input  logic [1:0]          parity_mode,
   input  logic                stop2,
   input  logic [MAX_BITS-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                busy,
   output logic [CW-1:0]       fifo_count,
   output logic                rs_tx
);

   state_e              state_q, state_d;
   logic [MAX_BITS-1:0] fifo_rdata;
   logic                fifo_full, fifo_empty;
   logic                load;
   logic [DIV_W-1:0]    div_q, cnt_q;
   logic [MAX_BITS-1:0] shift_q;
   logic [3:0]          nbits_q, bit_idx_q;
   logic                par_en_q, par_bit_q, stop2_q;
   logic                rs_tx_q, rs_tx_d, active_q;
   logic                bit_done, last_data, last_stop;
   logic [3:0]          len_clamped;
   logic                par_calc;
   parity_e             pm;

   assign tx_ready   = !fifo_full && !rst;
   assign rs_tx      = rs_tx_q;
   // active_q covers the final registered stop cycle after the FSM has gone idle.
   assign busy       = !fifo_empty || (state_q != StIdle) || active_q;
   assign pm         = parity_e'(parity_mode);
   assign bit_done   = (cnt_q == div_q);
   assign last_data  = (bit_idx_q == nbits_q - 4'd1);
   assign last_stop  = (bit_idx_q == {3'b000, stop2_q});

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .MAX_BITS   (MAX_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid && tx_ready),
      .pop   (load),
      .wdata (tx_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Frame configuration derived from the live inputs, captured on load.
   always_comb begin
      if (data_len < 4'd5) begin
         len_clamped = 4'd5;
      end else if (data_len > 4'(MAX_BITS)) begin
         len_clamped = 4'(MAX_BITS);
      end else begin
         len_clamped = data_len;
      end
      par_calc = 1'b0;
      for (int i = 0; i < MAX_BITS; i++) begin
         if (i < int'(len_clamped)) par_calc = par_calc ^ fifo_rdata[i];
      end
   end

   // State register; rs_tx is registered so the line lags the state by one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         rs_tx_q  <= 1'b1;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rs_tx_q  <= rs_tx_d;
         active_q <= (state_q != StIdle);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (!fifo_empty) state_d = StStart;
         StStart:  if (bit_done) state_d = StData;
         StData:   if (bit_done && last_data) state_d = par_en_q ? StParity : StStop;
         StParity: if (bit_done) state_d = StStop;
         StStop:   if (bit_done && last_stop) state_d = fifo_empty ? StIdle : StStart;
         default:  state_d = StIdle;
      endcase
   end

   // load pops the FIFO; from StStop it chains frames with no idle bit.
   always_comb begin
      rs_tx_d = 1'b1;
      load    = 1'b0;
      unique case (state_q)
         StIdle:   load = !fifo_empty;
         StStart:  rs_tx_d = 1'b0;
         StData:   rs_tx_d = shift_q[0];
         StParity: rs_tx_d = par_bit_q;
         StStop:   load = bit_done && last_stop && !fifo_empty;
         default:  rs_tx_d = 1'b1;
      endcase
   end

   // Baud counter, frame registers and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         div_q     <= '0;
         shift_q   <= '0;
         nbits_q   <= 4'd5;
         bit_idx_q <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
      end else if (load) begin
         cnt_q     <= '0;
         div_q     <= DIV_W'(baud_div(baud_sel));
         shift_q   <= fifo_rdata;
         nbits_q   <= len_clamped;
         bit_idx_q <= '0;
         par_en_q  <= (pm == ParEven) || (pm == ParOdd);
         par_bit_q <= (pm == ParOdd) ? ~par_calc : par_calc;
         stop2_q   <= stop2;
      end else if (state_q != StIdle) begin
         if (bit_done) begin
            cnt_q <= '0;
            if (state_q == StData) begin
               shift_q   <= shift_q >> 1;
               bit_idx_q <= last_data ? 4'd0 : bit_idx_q + 4'd1;
            end else if (state_q == StStop) begin
               bit_idx_q <= bit_idx_q + 4'd1;
            end
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: scoreboard of expected frames, decoded from rs_tx.
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] baud_sel = 3'd4;
   logic [3:0] data_len = 4'd8;
   logic [1:0] parity_mode = 2'b00;
   logic       stop2 = 1'b0;
   logic [8:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, busy, rs_tx;
   logic [2:0] fifo_count;

   int cyc = 0;
   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [8:0] data;
      int         len;
      int         par;     // 0 none, 1 even, 2 odd
      bit         two_stop;
      int         period;  // clocks per bit
   } exp_t;

   exp_t sb[$];

   uart_tx_cfg dut (
      .clk         (clk),
      .rst         (rst),
      .baud_sel    (baud_sel),
      .data_len    (data_len),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .rs_tx       (rs_tx)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end

   function automatic void expect_frame(input logic [8:0] d, input int len, input int par,
                                        input bit s2, input int period);
      exp_t e;
      e.data = d;
      e.len = len;
      e.par = par;
      e.two_stop = s2;
      e.period = period;
      sb.push_back(e);
   endfunction

   task automatic push_word(input logic [8:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic set_cfg(input logic [2:0] b, input logic [3:0] l, input logic [1:0] p,
                          input logic s);
      baud_sel = b;
      data_len = l;
      parity_mode = p;
      stop2 = s;
   endtask

   // Waits for a start bit, pops the scoreboard and samples every bit at its first,
   // middle and last clock. With last set, also requires the line idle right after.
   task automatic rx_frame(input string name, input int budget, input bit last,
                           output int start_c);
      exp_t e;
      logic [15:0] exp_bits, obs_bits;
      int nb, ones, waited, tgt, off;
      bit edge_bad;
      logic s;
      start_c = 0;
      exp_bits = '0;
      obs_bits = '0;
      edge_bad = 1'b0;
      nb = 0;
      ones = 0;
      waited = 0;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL %s: scoreboard empty, got no expected frame, required one", name);
         return;
      end
      e = sb.pop_front();
      exp_bits[nb] = 1'b0;
      nb++;
      for (int i = 0; i < e.len; i++) begin
         exp_bits[nb] = e.data[i];
         ones += int'(e.data[i]);
         nb++;
      end
      if (e.par == 1) begin
         exp_bits[nb] = ones[0];
         nb++;
      end else if (e.par == 2) begin
         exp_bits[nb] = ~ones[0];
         nb++;
      end
      exp_bits[nb] = 1'b1;
      nb++;
      if (e.two_stop) begin
         exp_bits[nb] = 1'b1;
         nb++;
      end
      while (rs_tx !== 1'b0 && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if (rs_tx !== 1'b0) begin
         fails++;
         $display("FAIL %s: start bit not seen in %0d cycles, rs_tx=%b required 0",
                  name, budget, rs_tx);
         return;
      end
      start_c = cyc;
      for (int k = 0; k < nb; k++) begin
         for (int j = 0; j < 3; j++) begin
            off = (j == 0) ? 0 : ((j == 1) ? e.period / 2 : e.period - 1);
            tgt = start_c + k * e.period + off;
            while (cyc < tgt) @(negedge clk);
            s = rs_tx;
            if (j == 1) obs_bits[k] = s;
            else if (s !== exp_bits[k]) edge_bad = 1'b1;
         end
      end
      if (obs_bits !== exp_bits || edge_bad) begin
         fails++;
         $display("FAIL %s: frame bits got %h (bit-boundary error %0b), required %h",
                  name, obs_bits, edge_bad, exp_bits);
      end
      if (last) begin
         @(negedge clk);
         tests++;
         if (busy !== 1'b0 || rs_tx !== 1'b1) begin
            fails++;
            $display("FAIL %s_idle: busy=%b rs_tx=%b after stop, required busy=0 rs_tx=1",
                     name, busy, rs_tx);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (rs_tx !== 1'b1) begin
         fails++;
         $display("FAIL reset_rs_tx: got %b required 1", rs_tx);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: got %b required 0", busy);
      end
      tests++;
      if (fifo_count !== 3'd0) begin
         fails++;
         $display("FAIL reset_count: got %0d required 0", fifo_count);
      end
      tests++;
      if (tx_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready: got %b required 0 during reset", tx_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (tx_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_after: got %b required 1", tx_ready);
      end
   endtask

   task automatic test_8n1();
      int cn, st;
      set_cfg(3'd4, 4'd8, 2'b00, 1'b0);
      expect_frame(9'h055, 8, 0, 1'b0, 435);
      push_word(9'h055);
      @(negedge clk);
      cn = cyc;
      tests++;
      if (fifo_count !== 3'd1) begin
         fails++;
         $display("FAIL 8n1_count: got %0d required 1 after push", fifo_count);
      end
      rx_frame("8n1_0x55", 20, 1'b0, st);
      tests++;
      if (st !== cn + 2) begin
         fails++;
         $display("FAIL 8n1_latency: start at cycle %0d required %0d", st, cn + 2);
      end
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL 8n1_busy_stop: got %b required 1 in last stop cycle", busy);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || rs_tx !== 1'b1 || cyc !== st + 4350) begin
         fails++;
         $display("FAIL 8n1_end: busy=%b rs_tx=%b at cycle %0d, required 0/1 at %0d",
                  busy, rs_tx, cyc, st + 4350);
      end
   endtask

   task automatic test_parity();
      int st;
      set_cfg(3'd5, 4'd7, 2'b01, 1'b0);
      expect_frame(9'h003, 7, 1, 1'b0, 196);
      push_word(9'h003);
      rx_frame("7e1_0x03", 20, 1'b1, st);
      expect_frame(9'h007, 7, 1, 1'b0, 196);
      push_word(9'h007);
      rx_frame("7e1_0x07", 20, 1'b1, st);
      set_cfg(3'd4, 4'd8, 2'b10, 1'b1);
      expect_frame(9'h007, 8, 2, 1'b1, 435);
      push_word(9'h007);
      rx_frame("8o2_0x07", 20, 1'b1, st);
   endtask

   task automatic test_back_to_back();
      logic [8:0] words [4] = '{9'h0C3, 9'h01E, 9'h0F0, 9'h081};
      int st, prev;
      set_cfg(3'd5, 4'd8, 2'b00, 1'b0);
      @(negedge clk);
      fork
         begin
            expect_frame(9'h011, 8, 0, 1'b0, 196);
            push_word(9'h011);
            repeat (10) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
               expect_frame(words[i], 8, 0, 1'b0, 196);
               push_word(words[i]);
            end
            @(negedge clk);
            tests++;
            if (fifo_count !== 3'd4) begin
               fails++;
               $display("FAIL fifo_full_count: got %0d required 4", fifo_count);
            end
            tests++;
            if (tx_ready !== 1'b0) begin
               fails++;
               $display("FAIL fifo_full_ready: got %b required 0", tx_ready);
            end
            push_word(9'h099);
            @(negedge clk);
            tests++;
            if (fifo_count !== 3'd4) begin
               fails++;
               $display("FAIL fifo_refuse: count got %0d required 4", fifo_count);
            end
         end
         begin
            rx_frame("b2b_f0", 50, 1'b0, st);
            prev = st;
            for (int i = 1; i < 5; i++) begin
               rx_frame($sformatf("b2b_f%0d", i), 50, i == 4, st);
               tests++;
               if (st !== prev + 1960) begin
                  fails++;
                  $display("FAIL b2b_gap%0d: start at %0d required %0d", i, st, prev + 1960);
               end
               prev = st;
            end
         end
      join
   endtask

   task automatic test_cfg_change();
      int s1, s2;
      set_cfg(3'd4, 4'd8, 2'b00, 1'b0);
      expect_frame(9'h0A7, 8, 0, 1'b0, 435);
      expect_frame(9'h016, 5, 0, 1'b0, 5209);
      push_word(9'h0A7);
      push_word(9'h016);
      fork
         begin
            rx_frame("cfg_old", 20, 1'b0, s1);
            rx_frame("cfg_new", 50, 1'b1, s2);
            tests++;
            if (s2 !== s1 + 4350) begin
               fails++;
               $display("FAIL cfg_gap: start at %0d required %0d", s2, s1 + 4350);
            end
         end
         begin
            repeat (100) @(negedge clk);
            baud_sel = 3'd0;
            data_len = 4'd5;
         end
      join
   endtask

   task automatic test_clamp();
      int st, waited;
      set_cfg(3'd5, 4'd2, 2'b11, 1'b0);
      expect_frame(9'h005, 5, 0, 1'b0, 196);
      push_word(9'h005);
      rx_frame("clamp_len2_par11", 20, 1'b1, st);
      set_cfg(3'd5, 4'd15, 2'b00, 1'b0);
      expect_frame(9'h0AB, 9, 0, 1'b0, 196);
      push_word(9'h0AB);
      rx_frame("clamp_len15", 20, 1'b1, st);
      set_cfg(3'd7, 4'd8, 2'b00, 1'b0);
      push_word(9'h001);
      waited = 0;
      while (rs_tx !== 1'b0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      st = cyc;
      tests++;
      if (rs_tx !== 1'b0) begin
         fails++;
         $display("FAIL clamp_baud7_start: rs_tx=%b required 0 within 20 cycles", rs_tx);
      end else begin
         while (cyc < st + 5208) @(negedge clk);
         tests++;
         if (rs_tx !== 1'b0) begin
            fails++;
            $display("FAIL clamp_baud7_low: rs_tx=%b at start+5208 required 0", rs_tx);
         end
         @(negedge clk);
         tests++;
         if (rs_tx !== 1'b1) begin
            fails++;
            $display("FAIL clamp_baud7_bit0: rs_tx=%b at start+5209 required 1", rs_tx);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int st, st2, waited;
      bit quiet;
      set_cfg(3'd5, 4'd8, 2'b00, 1'b0);
      @(negedge clk);
      fork
         begin
            expect_frame(9'h03C, 8, 0, 1'b0, 196);
            expect_frame(9'h000, 8, 0, 1'b0, 196);
            expect_frame(9'h05A, 8, 0, 1'b0, 196);
            push_word(9'h03C);
            push_word(9'h000);
            push_word(9'h05A);
         end
         begin
            rx_frame("rst_f0", 50, 1'b0, st);
            waited = 0;
            @(negedge clk);
            while (rs_tx !== 1'b0 && waited < 50) begin
               @(negedge clk);
               waited++;
            end
            st2 = cyc;
            tests++;
            if (st2 !== st + 1960) begin
               fails++;
               $display("FAIL rst_f1_start: at %0d required %0d", st2, st + 1960);
            end
            while (cyc < st2 + 3 * 196 + 98) @(negedge clk);
            tests++;
            if (rs_tx !== 1'b0) begin
               fails++;
               $display("FAIL rst_f1_data: rs_tx=%b required 0 before reset", rs_tx);
            end
            rst = 1'b1;
            @(negedge clk);
            tests++;
            if (rs_tx !== 1'b1) begin
               fails++;
               $display("FAIL rst_mid_rs_tx: got %b required 1", rs_tx);
            end
            tests++;
            if (fifo_count !== 3'd0) begin
               fails++;
               $display("FAIL rst_mid_count: got %0d required 0", fifo_count);
            end
            tests++;
            if (busy !== 1'b0) begin
               fails++;
               $display("FAIL rst_mid_busy: got %b required 0", busy);
            end
            rst = 1'b0;
            sb.delete();
            quiet = 1'b1;
            repeat (2 * 1960) begin
               @(negedge clk);
               if (rs_tx !== 1'b1) quiet = 1'b0;
            end
            tests++;
            if (!quiet) begin
               fails++;
               $display("FAIL rst_no_more_frames: rs_tx went low, required idle high");
            end
         end
      join
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_cfg_change();
      test_clamp();
      test_reset_mid_frame();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d frames left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter, the successor to the fixed 7-bit transmitter. It serialises frames with run-time selectable data length (5..MAX_BITS), parity (none/even/odd) and 1 or 2 stop bits, at one of six standard baud rates derived from a 50 MHz clock. A small input FIFO with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the board-control logic and the target's UART RX pin.

## Interface
- MAX_BITS, 9, widest data field supported (5..9)
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)
- DIV_W, 13, baud counter width
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- baud_sel  in  3  0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=256000; 6/7 → 9600
- data_len  in  4  data bits per frame; <5 clamps to 5, >MAX_BITS clamps to MAX_BITS
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
- stop2  in  1  1 = two stop bits
- tx_data  in  MAX_BITS  frame payload, LSB sent first, bits ≥ data_len ignored
- tx_valid  in  1  payload valid
- tx_ready  out  1  FIFO can accept (= not full)
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- rs_tx  out  1  serial line, idle high

## Operation
- Push on a clk edge with tx_valid && tx_ready. tx_ready depends only on full, so a push is refused when full even if a pop happens in the same cycle.
- FSM states: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE, or → START when the FIFO is non-empty.
- IDLE with FIFO non-empty: pop, latch the payload plus baud_sel/data_len/parity_mode/stop2 into frame registers, and enter START. Config changes mid-frame take effect only on the next frame.
- Divisor DIV comes from the table (5208, 2603, 1301, 867, 434, 195). Every bit lasts DIV+1 clocks. The bit counter is cleared at frame start; it does not free-run.
- Parity is computed over the data_len bits only. Even: the parity bit makes the total count of ones even. Odd: it makes the count odd.
- STOP lasts 1 or 2 bit periods, with rs_tx high.
- rst mid-frame: rs_tx returns high the next cycle, the FIFO is flushed and the FSM goes to IDLE. No partial frame is resumed.

## Timing
- Reset values: rs_tx=1, busy=0, fifo_count=0, FSM=IDLE. tx_ready=0 while rst is high and 1 on the first cycle after.
- Latency: push at edge N into an empty FIFO while idle gives a pop at edge N+1, and rs_tx falls after edge N+2.
- Frame length: (1 + data_len + parity? + 1 + stop2) × (DIV+1) clocks.
- Back-to-back: if the FIFO is non-empty at the end of the last stop bit, rs_tx falls on the very next bit boundary with zero idle cycles.
- busy deasserts in the same cycle rs_tx completes the final stop bit and the FIFO is empty.
- fifo_count updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

## Structure
- Package uart_pkg holds:
  - the divisor constants and the baud_sel → DIV function
  - the parity_mode encoding
  - the FSM state enum
- Sub-module uart_tx_fifo: synchronous FIFO with parameters FIFO_DEPTH and MAX_BITS, ports push/pop/full/empty/count, synchronous active-high rst.
- The top level holds the baud counter, frame registers, FSM and shift register.

## Test plan
- 8N1 at 115200 (baud_sel=4), single push of 0x55:
  - rs_tx low for 435 clocks, then 1,0,1,0,1,0,1,0 for 435 clocks each, then high.
  - Total frame is 4350 clocks; busy=0 afterwards.
- 7E1, data 0x03 (even count of ones) → parity bit 0. 8O2, data 0x07 → parity bit 0, and both stop bits are high for 870 clocks total.
- Fill the FIFO with 4 words while rs_tx is busy:
  - tx_ready=0 at fifo_count=4, and a 5th tx_valid is not accepted.
  - All 4 frames go out back-to-back with no idle gap between stop and start.
- Change baud_sel 4→0 and data_len 8→5 mid-frame: the current frame completes at 435 clocks/bit, and the next frame uses 5209 clocks/bit and 5 data bits.
- Clamp checks:
  - data_len=2 sends 5 bits; data_len=15 sends MAX_BITS bits.
  - baud_sel=7 gives 5209 clocks/bit; parity_mode=11 sends no parity bit.
- Assert rst during DATA of the second of 3 queued frames: rs_tx=1 the next cycle, fifo_count=0, busy=0, and no further frames are sent.
